// File: rtl/dbp_dbx_dec.sv
// Delta-bitplane decoder: rebuilds BLOCK_SIZE words from a base plus DATA_W+1 delta bitplanes.
// Optional overflow detection on err_o is compiled in with `define EBPC_DEC_OVF_CHECK_EN.

package ebpc_pkg;
  parameter int unsigned DATA_W     = 8;
  parameter int unsigned BLOCK_SIZE = 8;
  parameter int unsigned CNT_W      = $clog2(BLOCK_SIZE);

  // dbp[0] is the MSB (sign) plane; bit BLOCK_SIZE-2 of each plane belongs to delta 1.
  typedef struct packed {
    logic [DATA_W-1:0]               base;
    logic [0:DATA_W][BLOCK_SIZE-2:0] dbp;
  } dbp_block_t;
endpackage

module dbp_dbx_dec
  import ebpc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  dbp_block_t        dbp_block_i,
  input  logic              vld_i,
  output logic              rdy_o,
  input  logic              flush_i,
  output logic [DATA_W-1:0] data_o,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic              last_o,
  output logic              flush_o,
  output logic              idle_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_DRAIN = 2'b01
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nxt;
  logic [DATA_W-1:0] data_q, data_d;
  dbp_block_t        blk_q, blk_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic [DATA_W:0]   delta_tab [BLOCK_SIZE];
  logic [DATA_W:0]   delta_sel;
  logic [DATA_W:0]   sum;
  logic              at_last;

  // Transpose the latched bitplanes into one signed delta per word slot.
  assign delta_tab[0] = '0;
  for (genvar k = 1; k < BLOCK_SIZE; k++) begin : g_delta
    for (genvar j = 0; j <= DATA_W; j++) begin : g_bit
      assign delta_tab[k][DATA_W-j] = blk_q.dbp[j][BLOCK_SIZE-1-k];
    end
  end

  assign cnt_nxt   = cnt_q + CNT_W'(1);
  assign delta_sel = delta_tab[cnt_nxt];
  // Sign-extend the previous word so the add matches the encoder's DATA_W+1-bit differences.
  assign sum       = {data_q[DATA_W-1], data_q} + delta_sel;
  assign at_last   = (cnt_q == CNT_W'(BLOCK_SIZE - 1));

`ifdef EBPC_DEC_OVF_CHECK_EN
  logic err_q, err_d;
  logic ovf;
  // The sum leaves the signed DATA_W range exactly when its top two bits disagree.
  assign ovf   = sum[DATA_W] ^ sum[DATA_W-1];
  assign err_o = err_q;
`else
  logic unused_sum_msb;
  assign unused_sum_msb = sum[DATA_W];
  assign err_o          = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    blk_d   = blk_q;
    vld_d   = vld_q;
    last_d  = last_q;
    rdy_o   = 1'b0;
    idle_o  = 1'b0;
    flush_o = 1'b0;
`ifdef EBPC_DEC_OVF_CHECK_EN
    err_d   = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        rdy_o   = 1'b1;
        idle_o  = !vld_i;
        flush_o = flush_i & !vld_i;
        vld_d   = 1'b0;
        last_d  = 1'b0;
        if (vld_i) begin
          blk_d   = dbp_block_i;
          data_d  = dbp_block_i.base;
          cnt_d   = '0;
          vld_d   = 1'b1;
          state_d = S_DRAIN;
`ifdef EBPC_DEC_OVF_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end

      S_DRAIN: begin
        if (rdy_i && !at_last) begin
          data_d = sum[DATA_W-1:0];
          cnt_d  = cnt_nxt;
          last_d = (cnt_nxt == CNT_W'(BLOCK_SIZE - 1));
`ifdef EBPC_DEC_OVF_CHECK_EN
          if (ovf) err_d = 1'b1;
`endif
        end else if (rdy_i) begin
          // Last word leaves this cycle, so a waiting block is taken with no bubble.
          rdy_o = 1'b1;
          if (vld_i) begin
            blk_d  = dbp_block_i;
            data_d = dbp_block_i.base;
            cnt_d  = '0;
            last_d = 1'b0;
`ifdef EBPC_DEC_OVF_CHECK_EN
            err_d  = 1'b0;
`endif
          end else begin
            vld_d   = 1'b0;
            last_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        vld_d   = 1'b0;
        last_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      // NOTE: the block register is a plain flop bank, not a memory, so clearing it on reset is cheap.
      blk_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      blk_q   <= blk_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

`ifdef EBPC_DEC_OVF_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end
`endif

  assign data_o = data_q;
  assign vld_o  = vld_q;
  assign last_o = last_q;

endmodule

// File: tb/tb_dbp_dbx_dec.sv
// Directed self-checking bench for dbp_dbx_dec: table of whole blocks plus
// hand-written backpressure, back-to-back, flush and reset sequences.

module tb_dbp_dbx_dec;
  import ebpc_pkg::*;

  logic              clk = 1'b0;
  logic              rst_ni;
  dbp_block_t        dbp_block_i;
  logic              vld_i;
  logic              rdy_o;
  logic              flush_i;
  logic [DATA_W-1:0] data_o;
  logic              vld_o;
  logic              rdy_i;
  logic              last_o;
  logic              flush_o;
  logic              idle_o;
  logic              err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dbp_dbx_dec dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .dbp_block_i (dbp_block_i),
    .vld_i       (vld_i),
    .rdy_o       (rdy_o),
    .flush_i     (flush_i),
    .data_o      (data_o),
    .vld_o       (vld_o),
    .rdy_i       (rdy_i),
    .last_o      (last_o),
    .flush_o     (flush_o),
    .idle_o      (idle_o),
    .err_o       (err_o)
  );

  typedef struct packed {
    logic [7:0]      base;
    logic [8:0]      d1;
    logic [8:0]      d2;
    logic [8:0]      dr;
    logic [0:7][7:0] exp;
    logic [0:7]      errs;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packs delta 1, delta 2 and a shared value for deltas 3..7 into bitplanes.
  function automatic dbp_block_t mk_block(input logic [7:0] base, input logic [8:0] d1,
                                          input logic [8:0] d2, input logic [8:0] dr);
    dbp_block_t b;
    logic [8:0] d [8];
    b      = '0;
    b.base = base;
    d[0]   = '0;
    d[1]   = d1;
    d[2]   = d2;
    for (int k = 3; k < 8; k++) d[k] = dr;
    for (int k = 1; k < 8; k++)
      for (int j = 0; j <= 8; j++)
        b.dbp[j][7-k] = d[k][8-j];
    return b;
  endfunction

  task automatic run_block(input vec_t v, input string tag);
    dbp_block_i = mk_block(v.base, v.d1, v.d2, v.dr);
    vld_i = 1'b1;
    rdy_i = 1'b1;
    #1;
    check({tag, " idle rdy_o"}, 32'(rdy_o), 32'd1);
    @(posedge clk); #1;
    vld_i = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s data[%0d]", tag, i), 32'(data_o), 32'(v.exp[i]));
      check($sformatf("%s vld[%0d]", tag, i), 32'(vld_o), 32'd1);
      check($sformatf("%s last[%0d]", tag, i), 32'(last_o), 32'(i == 7));
      check($sformatf("%s rdy_o[%0d]", tag, i), 32'(rdy_o), 32'(i == 7));
      check($sformatf("%s err[%0d]", tag, i), 32'(err_o), 32'(v.errs[i]));
      @(posedge clk); #2;
    end
    check({tag, " end vld_o"}, 32'(vld_o), 32'd0);
    check({tag, " end idle_o"}, 32'(idle_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int cyc;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    vecs[0] = '{base: 8'h05, d1: 9'h001, d2: 9'h001, dr: 9'h001,
                exp: {8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C}, errs: 8'b0};
    vecs[1] = '{base: 8'h80, d1: 9'h0FF, d2: 9'h101, dr: 9'h000,
                exp: {8'h80, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80}, errs: 8'b0};
    vecs[2] = '{base: 8'h03, d1: 9'h1FE, d2: 9'h1FE, dr: 9'h1FE,
                exp: {8'h03, 8'h01, 8'hFF, 8'hFD, 8'hFB, 8'hF9, 8'hF7, 8'hF5}, errs: 8'b0};
    vecs[3] = '{base: 8'h64, d1: 9'h001, d2: 9'h001, dr: 9'h001,
                exp: {8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69, 8'h6A, 8'h6B}, errs: 8'b0};

    rst_ni      = 1'b0;
    vld_i       = 1'b0;
    rdy_i       = 1'b0;
    flush_i     = 1'b0;
    dbp_block_i = '0;
    #12;
    check("reset vld_o", 32'(vld_o), 32'd0);
    check("reset data_o", 32'(data_o), 32'd0);
    check("reset last_o", 32'(last_o), 32'd0);
    check("reset rdy_o", 32'(rdy_o), 32'd1);
    check("reset idle_o", 32'(idle_o), 32'd1);
    check("reset flush_o", 32'(flush_o), 32'd0);
    check("reset err_o", 32'(err_o), 32'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 3; v++) run_block(vecs[v], $sformatf("vec%0d", v));

    // Backpressure: rdy_i follows 1,0,0,1 repeating.
    dbp_block_i = mk_block(8'h05, 9'h001, 9'h001, 9'h001);
    vld_i = 1'b1;
    @(posedge clk); #1;
    vld_i = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 64) begin
      check($sformatf("bp data c%0d", cyc), 32'(data_o), 32'(5 + idx));
      check($sformatf("bp vld c%0d", cyc), 32'(vld_o), 32'd1);
      check($sformatf("bp last c%0d", cyc), 32'(last_o), 32'(idx == 7));
      rdy_i = pat[cyc % 4];
      #1;
      check($sformatf("bp rdy_o c%0d", cyc), 32'(rdy_o), 32'(rdy_i && idx == 7));
      if (rdy_i) idx++;
      cyc++;
      @(posedge clk); #1;
    end
    check("bp words drained", 32'(idx), 32'd8);
    check("bp end vld_o", 32'(vld_o), 32'd0);
    rdy_i = 1'b1;

    // Back-to-back blocks with vld_i held.
    dbp_block_i = mk_block(8'h05, 9'h001, 9'h001, 9'h001);
    vld_i = 1'b1;
    @(posedge clk); #1;
    dbp_block_i = mk_block(8'd100, 9'h001, 9'h001, 9'h001);
    for (int n = 0; n < 16; n++) begin
      if (n == 8) vld_i = 1'b0;
      #1;
      check($sformatf("b2b data[%0d]", n), 32'(data_o), (n < 8) ? 32'(5 + n) : 32'(100 + n - 8));
      check($sformatf("b2b vld[%0d]", n), 32'(vld_o), 32'd1);
      check($sformatf("b2b rdy_o[%0d]", n), 32'(rdy_o), 32'(n == 7 || n == 15));
      @(posedge clk); #1;
    end
    check("b2b end vld_o", 32'(vld_o), 32'd0);

    // Flush in idle, and block beating flush.
    flush_i = 1'b1;
    #1;
    check("flush flush_o", 32'(flush_o), 32'd1);
    check("flush idle_o", 32'(idle_o), 32'd1);
    vld_i = 1'b1;
    #1;
    check("flush+vld flush_o", 32'(flush_o), 32'd0);
    check("flush+vld idle_o", 32'(idle_o), 32'd0);
    vld_i   = 1'b0;
    flush_i = 1'b0;
    #1;
    check("flush off flush_o", 32'(flush_o), 32'd0);
    @(posedge clk); #1;
    check("flush no accept vld_o", 32'(vld_o), 32'd0);

    // Reset mid-block, while word 3 is presented.
    dbp_block_i = mk_block(8'h05, 9'h001, 9'h001, 9'h001);
    vld_i = 1'b1;
    @(posedge clk); #1;
    vld_i = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    check("pre-reset data_o", 32'(data_o), 32'd8);
    rst_ni = 1'b0;
    #1;
    check("mid-reset vld_o", 32'(vld_o), 32'd0);
    check("mid-reset data_o", 32'(data_o), 32'd0);
    check("mid-reset last_o", 32'(last_o), 32'd0);
    check("mid-reset rdy_o", 32'(rdy_o), 32'd1);
    #2;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    run_block(vecs[3], "post-reset");

`ifdef EBPC_DEC_OVF_CHECK_EN
    run_block('{base: 8'h7F, d1: 9'h001, d2: 9'h000, dr: 9'h000,
                exp: {8'h7F, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80},
                errs: 8'b0111_1111}, "ovf");
    check("ovf sticky in idle", 32'(err_o), 32'd1);
    run_block(vecs[0], "ovf-clear");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
